// File: rtl/sd_sector_arb.sv
// sd_sector_arb: round-robin share of the user_io SD image channel
// between two sector requesters, with timeout, count and abort checks.
module sd_sector_arb #(
  parameter int TIMEOUT_W = 24
) (
  input  logic        clk_sys,
  input  logic        res_n_i,
  input  logic [1:0]  req_rd,
  input  logic [1:0]  req_wr,
  input  logic [31:0] req_lba0,
  input  logic [31:0] req_lba1,
  output logic [1:0]  req_done,
  output logic [1:0]  req_err,
  output logic [8:0]  req_buff_addr,
  output logic [7:0]  req_buff_dout,
  output logic [1:0]  req_buff_wr,
  output logic [1:0]  req_din_strobe,
  input  logic [7:0]  req_buff_din0,
  input  logic [7:0]  req_buff_din1,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic [8:0]  sd_buff_addr,
  input  logic [7:0]  sd_buff_dout,
  input  logic        sd_buff_wr,
  input  logic        sd_din_strobe,
  output logic [7:0]  sd_buff_din,
  input  logic        img_mounted,
  output logic        busy,
  output logic        grant_id
);

  typedef enum logic [1:0] {
    IDLE, REQ, XFER, DONE
  } state_t;

  localparam logic [TIMEOUT_W-1:0] TMO_LAST =
    TIMEOUT_W'((1 << TIMEOUT_W) - 2);

  state_t state, state_d;

  logic                 last_grant;
  logic                 dir;
  logic                 abort;
  logic [9:0]           cnt;
  logic [TIMEOUT_W-1:0] tmo;

  logic gnt_d, done_d, err_d;
  logic pend0, pend1;
  logic fwd, strobe;

  assign pend0  = req_rd[0] | req_wr[0];
  assign pend1  = req_rd[1] | req_wr[1];
  assign fwd    = (state == REQ) | (state == XFER);
  assign strobe = dir ? sd_din_strobe : sd_buff_wr;

  always_ff @(posedge clk_sys or negedge res_n_i) begin
    if (!res_n_i) state <= IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d = state;
    gnt_d   = grant_id;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state)
      IDLE: begin
        if (pend0 | pend1) begin
          state_d = REQ;
          gnt_d   = (pend0 & pend1) ? ~last_grant : pend1;
        end
      end
      REQ: begin
        if (sd_ack) begin
          state_d = XFER;
        end else if ((tmo == TMO_LAST) | img_mounted) begin
          state_d = DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end
      end
      XFER: begin
        if (!sd_ack) begin
          state_d = DONE;
          done_d  = 1'b1;
          err_d   = abort | img_mounted | (cnt != 10'd512);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge res_n_i) begin
    if (!res_n_i) begin
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
      sd_lba     <= '0;
      dir        <= 1'b0;
      abort      <= 1'b0;
      cnt        <= '0;
      tmo        <= '0;
      req_done   <= '0;
      req_err    <= '0;
    end else begin
      req_done <= {done_d & grant_id, done_d & ~grant_id};
      req_err  <= {err_d & grant_id, err_d & ~grant_id};
      if (state == IDLE && state_d == REQ) begin
        grant_id <= gnt_d;
        sd_lba   <= gnt_d ? req_lba1 : req_lba0;
        dir      <= req_wr[gnt_d] & ~req_rd[gnt_d];
        abort    <= 1'b0;
        cnt      <= '0;
        tmo      <= '0;
      end
      if (state == REQ) tmo <= tmo + 1'b1;
      if (state == XFER) begin
        // saturate one past a full sector so overruns stay visible
        if (strobe && cnt != 10'd513) cnt <= cnt + 10'd1;
        if (img_mounted) abort <= 1'b1;
      end
      if (state == DONE) last_grant <= grant_id;
    end
  end

  assign sd_rd          = (state == REQ) & ~dir;
  assign sd_wr          = (state == REQ) & dir;
  assign busy           = (state != IDLE);
  assign req_buff_addr  = sd_buff_addr;
  assign req_buff_dout  = sd_buff_dout;
  assign req_buff_wr    = {fwd & grant_id & sd_buff_wr,
                           fwd & ~grant_id & sd_buff_wr};
  assign req_din_strobe = {fwd & grant_id & sd_din_strobe,
                           fwd & ~grant_id & sd_din_strobe};
  assign sd_buff_din    = grant_id ? req_buff_din1 : req_buff_din0;

endmodule

// File: tb/tb_sd_sector_arb.sv
// tb_sd_sector_arb: directed checks of grant order, strobe routing,
// completion status, timeout and reset behaviour.
module tb_sd_sector_arb;

  logic        clk_sys = 1'b0;
  logic        res_n_i;
  logic [1:0]  req_rd, req_wr;
  logic [31:0] req_lba0, req_lba1;
  logic [1:0]  req_done, req_err;
  logic [8:0]  req_buff_addr;
  logic [7:0]  req_buff_dout;
  logic [1:0]  req_buff_wr, req_din_strobe;
  logic [7:0]  req_buff_din0, req_buff_din1;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic        sd_buff_wr, sd_din_strobe;
  logic [7:0]  sd_buff_din;
  logic        img_mounted, busy, grant_id;

  int checks = 0;
  int failures = 0;

  sd_sector_arb #(.TIMEOUT_W(4)) dut (
    .clk_sys(clk_sys), .res_n_i(res_n_i),
    .req_rd(req_rd), .req_wr(req_wr),
    .req_lba0(req_lba0), .req_lba1(req_lba1),
    .req_done(req_done), .req_err(req_err),
    .req_buff_addr(req_buff_addr), .req_buff_dout(req_buff_dout),
    .req_buff_wr(req_buff_wr), .req_din_strobe(req_din_strobe),
    .req_buff_din0(req_buff_din0), .req_buff_din1(req_buff_din1),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_wr(sd_buff_wr), .sd_din_strobe(sd_din_strobe),
    .sd_buff_din(sd_buff_din), .img_mounted(img_mounted),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset;
    res_n_i = 1'b0;
    tick;
    tick;
    res_n_i = 1'b1;
    tick;
  endtask

  // DUT is in REQ on entry; returns one cycle into IDLE
  task automatic xfer(input int n, input bit wr, input bit g,
                      input bit mnt, input bit exp_err,
                      input string tag);
    int bad;
    logic [1:0] exp_s;
    logic [1:0] exp_bw, exp_ds;
    logic [7:0] d;
    bad = 0;
    exp_s  = g ? 2'b10 : 2'b01;
    exp_bw = wr ? 2'b00 : exp_s;
    exp_ds = wr ? exp_s : 2'b00;
    sd_ack = 1'b1;
    tick;
    chk({tag, "_strobe_drop"}, {sd_rd, sd_wr}, 2'b00);
    sd_buff_wr    = !wr;
    sd_din_strobe = wr;
    for (int i = 0; i < n; i++) begin
      d = 8'(i);
      sd_buff_addr  = 9'(i);
      sd_buff_dout  = d ^ 8'h5a;
      req_buff_din0 = d;
      req_buff_din1 = ~d;
      img_mounted   = mnt && (i == 10);
      #1;
      if (req_buff_wr !== exp_bw || req_din_strobe !== exp_ds ||
          req_buff_addr !== 9'(i) || req_buff_dout !== (d ^ 8'h5a) ||
          sd_buff_din !== (g ? ~d : d))
        bad++;
      tick;
    end
    img_mounted   = 1'b0;
    sd_buff_wr    = 1'b0;
    sd_din_strobe = 1'b0;
    sd_ack        = 1'b0;
    chk({tag, "_routing"}, bad, 0);
    tick;
    chk({tag, "_done"}, req_done, exp_s);
    chk({tag, "_err"}, req_err, exp_err ? exp_s : 2'b00);
    req_rd[g] = 1'b0;
    req_wr[g] = 1'b0;
    tick;
    chk({tag, "_done_clr"}, req_done, 2'b00);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    req_rd = '0; req_wr = '0;
    req_lba0 = '0; req_lba1 = '0;
    req_buff_din0 = '0; req_buff_din1 = '0;
    sd_ack = 0; sd_buff_addr = '0; sd_buff_dout = '0;
    sd_buff_wr = 0; sd_din_strobe = 0; img_mounted = 0;
    do_reset;

    chk("rst_rdwr", {sd_rd, sd_wr}, 2'b00);
    chk("rst_lba", sd_lba, 32'h0);
    chk("rst_done", {req_done, req_err}, 4'h0);
    chk("rst_busy_gnt", {busy, grant_id}, 2'b00);

    // single read from requester 0
    req_lba0 = 32'h1234;
    req_rd[0] = 1'b1;
    tick;
    chk("rd0_sd_rd", {sd_rd, sd_wr}, 2'b10);
    chk("rd0_lba", sd_lba, 32'h1234);
    chk("rd0_busy", busy, 1'b1);
    xfer(512, 1'b0, 1'b0, 1'b0, 1'b0, "rd0");
    chk("rd0_idle", busy, 1'b0);

    // tie after requester 0 was last served: requester 1 first
    req_lba0 = 32'h100; req_lba1 = 32'h200;
    req_rd = 2'b11;
    tick;
    chk("tieA_gnt", grant_id, 1'b1);
    chk("tieA_lba", sd_lba, 32'h200);
    xfer(512, 1'b0, 1'b1, 1'b0, 1'b0, "tieA1");
    tick;
    chk("tieA_gnt2", grant_id, 1'b0);
    chk("tieA_lba2", sd_lba, 32'h100);
    xfer(512, 1'b0, 1'b0, 1'b0, 1'b0, "tieA0");

    // tie straight after reset: requester 0 first
    do_reset;
    req_rd = 2'b11;
    tick;
    chk("tieB_gnt", grant_id, 1'b0);
    xfer(512, 1'b0, 1'b0, 1'b0, 1'b0, "tieB0");
    tick;
    chk("tieB_gnt2", grant_id, 1'b1);
    xfer(512, 1'b0, 1'b1, 1'b0, 1'b0, "tieB1");

    // write from requester 1
    req_lba1 = 32'h77;
    req_wr[1] = 1'b1;
    tick;
    chk("wr1_sd_wr", {sd_rd, sd_wr}, 2'b01);
    chk("wr1_lba", sd_lba, 32'h77);
    xfer(512, 1'b1, 1'b1, 1'b0, 1'b0, "wr1");

    // rd wins when both direction bits are set
    req_rd[0] = 1'b1; req_wr[0] = 1'b1;
    tick;
    chk("rdwr_dir", {sd_rd, sd_wr}, 2'b10);
    xfer(512, 1'b0, 1'b0, 1'b0, 1'b0, "rdwr");

    // short and overlong transfers
    req_rd[0] = 1'b1;
    tick;
    xfer(100, 1'b0, 1'b0, 1'b0, 1'b1, "short");
    req_rd[1] = 1'b1;
    tick;
    xfer(513, 1'b0, 1'b1, 1'b0, 1'b1, "over");

    // remount during XFER
    req_rd[0] = 1'b1;
    tick;
    xfer(512, 1'b0, 1'b0, 1'b1, 1'b1, "abort");

    // timeout with no ack
    req_rd[0] = 1'b1;
    tick;
    c = 0;
    while (sd_rd && c < 40) begin
      c++;
      tick;
    end
    chk("tmo_cycles", c, 15);
    chk("tmo_done", req_done, 2'b01);
    chk("tmo_err", req_err, 2'b01);
    req_rd[0] = 1'b0;
    tick;
    chk("tmo_busy", busy, 1'b0);

    // reset during REQ
    req_rd[0] = 1'b1;
    tick;
    chk("rstreq_pre", sd_rd, 1'b1);
    res_n_i = 1'b0;
    #1;
    chk("rstreq_rd", sd_rd, 1'b0);
    chk("rstreq_busy", busy, 1'b0);
    chk("rstreq_lba", sd_lba, 32'h0);
    req_rd[0] = 1'b0;
    tick;
    chk("rstreq_done", req_done, 2'b00);
    res_n_i = 1'b1;
    tick;
    tick;
    chk("rstreq_done2", req_done, 2'b00);
    chk("rstreq_idle", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
